// File: rtl/freq_div_pkg.sv
// Shared constants for dividers running off the 50 MHz board clock.
// Divisor values count half-periods of the output square wave.
package freq_div_pkg;

   localparam int unsigned F_SYS_HZ  = 50_000_000;
   localparam int unsigned DIV_1HZ   = 25_000_000;
   localparam int unsigned DIV_10KHZ = 2_500;
   localparam int unsigned DIV_1KHZ  = 25_000;
   localparam int          DEF_DIV_W = 32;

   function automatic int unsigned half_period_div(input int unsigned hz);
      return F_SYS_HZ / (2 * hz);
   endfunction

endpackage

// File: rtl/clk_div_channel.sv
// One divider channel: half-period counter, active/shadow divisor pair,
// registered square wave and toggle strobe.
module clk_div_channel
   import freq_div_pkg::*;
#(
   parameter int               DIV_W    = DEF_DIV_W,
   parameter logic [DIV_W-1:0] INIT_DIV = DIV_W'(1)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             en,
   input  logic             sync_clr,
   input  logic             wr,
   input  logic [DIV_W-1:0] wr_data,
   output logic             clk_out,
   output logic             tick,
   output logic             pend
);

   logic [DIV_W-1:0] cnt;
   logic [DIV_W-1:0] div_act;
   logic [DIV_W-1:0] div_shd;
   logic [DIV_W-1:0] last;
   logic             at_wrap;
   logic             overrun;

   assign last    = div_act - DIV_W'(1);
   assign at_wrap = (cnt == last);
   // A cold load below the held count leaves cnt past the end; recover silently.
   assign overrun = (cnt > last);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt     <= '0;
         clk_out <= 1'b0;
         tick    <= 1'b0;
         pend    <= 1'b0;
         div_act <= INIT_DIV;
         div_shd <= INIT_DIV;
      end else if (sync_clr) begin
         cnt     <= '0;
         clk_out <= 1'b0;
         tick    <= 1'b0;
         pend    <= 1'b0;
         if (wr) begin
            div_act <= wr_data;
            div_shd <= wr_data;
         end else begin
            div_act <= div_shd;
         end
      end else if (!en) begin
         tick <= 1'b0;
         if (wr) begin
            div_act <= wr_data;
            div_shd <= wr_data;
            pend    <= 1'b0;
         end
      end else if (overrun) begin
         cnt  <= '0;
         tick <= 1'b0;
         if (wr) begin
            div_shd <= wr_data;
            pend    <= 1'b1;
         end
      end else if (at_wrap) begin
         cnt     <= '0;
         clk_out <= ~clk_out;
         tick    <= 1'b1;
         pend    <= 1'b0;
         // A write landing on the wrap takes effect right here.
         if (wr) begin
            div_act <= wr_data;
            div_shd <= wr_data;
         end else begin
            div_act <= div_shd;
         end
      end else begin
         cnt  <= cnt + DIV_W'(1);
         tick <= 1'b0;
         if (wr) begin
            div_shd <= wr_data;
            pend    <= 1'b1;
         end
      end
   end

endmodule

// File: rtl/param_clk_divider.sv
// Multi-channel runtime-programmable clock divider: write decode, error
// strobe and one clk_div_channel per output.
module param_clk_divider
   import freq_div_pkg::*;
#(
   parameter int                  CH        = 2,
   parameter int                  DIV_W     = DEF_DIV_W,
   parameter logic [CH*DIV_W-1:0] INIT_DIVS = {32'(DIV_10KHZ), 32'(DIV_1HZ)},
   parameter int                  SEL_W     = (CH > 1) ? $clog2(CH) : 1
) (
   input  logic             clk_50MHz,
   input  logic             reset,
   input  logic [CH-1:0]    en,
   input  logic             sync_clr,
   input  logic             div_wr,
   input  logic [SEL_W-1:0] div_sel,
   input  logic [DIV_W-1:0] div_data,
   output logic [CH-1:0]    clk_out,
   output logic [CH-1:0]    tick,
   output logic [CH-1:0]    pend,
   output logic             div_err
);

   logic          sel_ok;
   logic          data_ok;
   logic          wr_ok;
   logic [CH-1:0] ch_wr;

   assign sel_ok  = ({1'b0, div_sel} < (SEL_W + 1)'(CH));
   assign data_ok = (div_data != '0);
   assign wr_ok   = div_wr && sel_ok && data_ok;

   always_ff @(posedge clk_50MHz or negedge reset) begin
      if (!reset) begin
         div_err <= 1'b0;
      end else begin
         div_err <= div_wr && !(sel_ok && data_ok);
      end
   end

   for (genvar i = 0; i < CH; i++) begin : g_ch
      assign ch_wr[i] = wr_ok && (div_sel == SEL_W'(i));

      clk_div_channel #(
         .DIV_W    (DIV_W),
         .INIT_DIV (INIT_DIVS[i*DIV_W +: DIV_W])
      ) u_ch (
         .clk      (clk_50MHz),
         .rst_n    (reset),
         .en       (en[i]),
         .sync_clr (sync_clr),
         .wr       (ch_wr[i]),
         .wr_data  (div_data),
         .clk_out  (clk_out[i]),
         .tick     (tick[i]),
         .pend     (pend[i])
      );
   end

endmodule
